// File: rtl/synchronizer_filt_asr.sv
// ============================================================================
// synchronizer_filt_asr : per-channel multi-flop synchronizer with a
//                         consecutive-cycle debounce filter and edge pulses
// Revision 1.0
// ============================================================================
`default_nettype none

module synchronizer_filt_asr #(
   parameter int              WIDTH   = 4,
   parameter int              STAGES  = 2,
   parameter int              FILT    = 3,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             rclk,
   input  logic             arst_l,
   input  logic [WIDTH-1:0] async_in,
   output logic [WIDTH-1:0] sync_out,
   output logic [WIDTH-1:0] filt_out,
   output logic [WIDTH-1:0] rise_pulse,
   output logic [WIDTH-1:0] fall_pulse,
   output logic             any_change
);

   localparam int                c_cnt_w    = $clog2(FILT + 1);
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(FILT - 1);
   localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      logic [STAGES-1:0]  chain_q;
      logic               filt_q;
      logic               filt_d;
      logic               rise_q;
      logic               rise_d;
      logic               fall_q;
      logic               fall_d;
      logic [c_cnt_w-1:0] cnt_q;
      logic [c_cnt_w-1:0] cnt_d;
      logic               w_sync;

      // Only chain_q[0] touches the asynchronous input; stages are wired back to back.
      always_ff @(posedge rclk or negedge arst_l) begin
         if (!arst_l) begin
            chain_q <= {STAGES{RST_VAL[i]}};
         end else begin
            chain_q <= {chain_q[STAGES-2:0], async_in[i]};
         end
      end

      assign w_sync = chain_q[STAGES-1];

      always_comb begin
         cnt_d  = '0;
         filt_d = filt_q;
         rise_d = 1'b0;
         fall_d = 1'b0;
         if (w_sync != filt_q) begin
            if (cnt_q == c_cnt_last) begin
               filt_d = w_sync;
               rise_d = w_sync;
               fall_d = ~w_sync;
            end else begin
               cnt_d = cnt_q + c_cnt_one;
            end
         end
      end

      always_ff @(posedge rclk or negedge arst_l) begin
         if (!arst_l) begin
            filt_q <= RST_VAL[i];
            cnt_q  <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
         end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
         end
      end

      assign sync_out[i]   = w_sync;
      assign filt_out[i]   = filt_q;
      assign rise_pulse[i] = rise_q;
      assign fall_pulse[i] = fall_q;
   end

   assign any_change = |(rise_pulse | fall_pulse);

endmodule

`default_nettype wire

// File: tb/tb_synchronizer_filt_asr.sv
// ============================================================================
// tb_synchronizer_filt_asr : directed checks on three parameterisations
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_synchronizer_filt_asr;

   logic       rclk;
   logic       clk_en;
   logic       rst_a, rst_b, rst_c;
   logic [3:0] async_a, async_b, async_c;

   logic [3:0] sync_a, filt_a, rise_a, fall_a;
   logic [3:0] sync_b, filt_b, rise_b, fall_b;
   logic [3:0] sync_c, filt_c, rise_c, fall_c;
   logic       any_a, any_b, any_c;

   int n_checks;
   int n_fail;

   synchronizer_filt_asr dut_a (
      .rclk(rclk), .arst_l(rst_a), .async_in(async_a), .sync_out(sync_a),
      .filt_out(filt_a), .rise_pulse(rise_a), .fall_pulse(fall_a), .any_change(any_a)
   );

   synchronizer_filt_asr #(.WIDTH(4), .STAGES(3), .FILT(1)) dut_b (
      .rclk(rclk), .arst_l(rst_b), .async_in(async_b), .sync_out(sync_b),
      .filt_out(filt_b), .rise_pulse(rise_b), .fall_pulse(fall_b), .any_change(any_b)
   );

   synchronizer_filt_asr #(.WIDTH(4), .RST_VAL(4'hF)) dut_c (
      .rclk(rclk), .arst_l(rst_c), .async_in(async_c), .sync_out(sync_c),
      .filt_out(filt_c), .rise_pulse(rise_c), .fall_pulse(fall_c), .any_change(any_c)
   );

   // Free-running clock that can be frozen low to exercise reset without edges.
   initial rclk = 1'b0;
   always begin
      #5;
      if (clk_en) rclk = ~rclk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge rclk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      clk_en   = 1'b1;
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      async_a = 4'h0; async_b = 4'h0; async_c = 4'hF;
      #12;
      chk("rst_a_sync", sync_a, 4'h0);
      chk("rst_a_filt", filt_a, 4'h0);
      chk("rst_a_rise", rise_a, 4'h0);
      chk("rst_a_fall", fall_a, 4'h0);
      chk("rst_a_any",  any_a,  1'b0);
      chk("rst_b_filt", filt_b, 4'h0);
      chk("rst_c_sync", sync_c, 4'hF);
      chk("rst_c_filt", filt_c, 4'hF);
      chk("rst_c_pulse", {rise_c, fall_c}, 8'h00);
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

      // Clean rising step on channel 0
      async_a = 4'b0001;
      tick();
      chk("step0_sync_e1", sync_a, 4'h0);
      tick();
      chk("step0_sync_e2", sync_a, 4'h1);
      tick();
      tick();
      chk("step0_filt_e4", filt_a, 4'h0);
      chk("step0_rise_e4", rise_a, 4'h0);
      tick();
      chk("step0_filt_e5", filt_a, 4'h1);
      chk("step0_rise_e5", rise_a, 4'h1);
      chk("step0_fall_e5", fall_a, 4'h0);
      chk("step0_any_e5",  any_a,  1'b1);
      tick();
      chk("step0_rise_e6", rise_a, 4'h0);
      chk("step0_any_e6",  any_a,  1'b0);
      chk("step0_filt_e6", filt_a, 4'h1);

      // Two-cycle glitch on channel 1 must vanish
      async_a[1] = 1'b1;
      tick();
      tick();
      async_a[1] = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("glitch1_filt", filt_a, 4'h1);
         chk("glitch1_pulse", {rise_a, fall_a}, 8'h00);
      end

      // Following clean step on channel 1 needs the full latency again
      async_a[1] = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      chk("step1_filt_e4", filt_a, 4'h1);
      tick();
      chk("step1_filt_e5", filt_a, 4'h3);
      chk("step1_rise_e5", rise_a, 4'h2);

      // Falling step on channel 2 after it settles high
      async_a[2] = 1'b1;
      for (int k = 0; k < 6; k++) tick();
      chk("ch2_settled", filt_a, 4'h7);
      async_a[2] = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      chk("fall2_e4", fall_a, 4'h0);
      tick();
      chk("fall2_fall_e5", fall_a, 4'h4);
      chk("fall2_rise_e5", rise_a, 4'h0);
      chk("fall2_filt_e5", filt_a, 4'h3);
      chk("fall2_any_e5",  any_a,  1'b1);
      tick();
      chk("fall2_fall_e6", fall_a, 4'h0);

      // FILT=1, STAGES=3 instance
      async_b = 4'b1010;
      tick();
      tick();
      chk("b_sync_e2", sync_b, 4'h0);
      tick();
      chk("b_sync_e3", sync_b, 4'hA);
      chk("b_filt_e3", filt_b, 4'h0);
      tick();
      chk("b_filt_e4", filt_b, 4'hA);
      chk("b_rise_e4", rise_b, 4'hA);
      chk("b_fall_e4", fall_b, 4'h0);
      chk("b_any_e4",  any_b,  1'b1);
      tick();
      chk("b_rise_e5", rise_b, 4'h0);

      // Reset mid-count on channel 3 with the clock frozen
      async_a[3] = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      @(negedge rclk);
      clk_en = 1'b0;
      #2;
      rst_a = 1'b0;
      #1;
      chk("midrst_sync", sync_a, 4'h0);
      chk("midrst_filt", filt_a, 4'h0);
      chk("midrst_pulse", {rise_a, fall_a}, 8'h00);
      chk("midrst_any", any_a, 1'b0);
      async_a = 4'h0;
      #3;
      rst_a = 1'b1;
      #1;
      clk_en = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("postrst_filt", filt_a, 4'h0);
         chk("postrst_pulse", {rise_a, fall_a}, 8'h00);
      end

      // RST_VAL=F instance: idle at F, then fall on all channels
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("c_idle_pulse", {rise_c, fall_c}, 8'h00);
         chk("c_idle_filt", filt_c, 4'hF);
      end
      async_c = 4'h0;
      for (int k = 0; k < 4; k++) tick();
      chk("c_fall_e4", fall_c, 4'h0);
      chk("c_filt_e4", filt_c, 4'hF);
      tick();
      chk("c_fall_e5", fall_c, 4'hF);
      chk("c_rise_e5", rise_c, 4'h0);
      chk("c_filt_e5", filt_c, 4'h0);
      chk("c_any_e5",  any_c,  1'b1);
      tick();
      chk("c_fall_e6", fall_c, 4'h0);

      // Release with input differing from RST_VAL
      tick();
      rst_c = 1'b0;
      #2;
      chk("c_rst2_filt", filt_c, 4'hF);
      chk("c_rst2_sync", sync_c, 4'hF);
      chk("c_rst2_pulse", {rise_c, fall_c}, 8'h00);
      #2;
      rst_c = 1'b1;
      tick();
      chk("c_rel_e1_pulse", {rise_c, fall_c}, 8'h00);
      for (int k = 0; k < 3; k++) tick();
      chk("c_rel_e4_filt", filt_c, 4'hF);
      tick();
      chk("c_rel_e5_filt", filt_c, 4'h0);
      chk("c_rel_e5_fall", fall_c, 4'hF);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
